// File: rtl/clock_divider_1hz.sv
// rtl/clock_divider_1hz.sv - free-running heartbeat divider, 50 % duty LED output
// Optional registered TICK output when CLKDIV_TICK_EN is defined.
module clock_divider_1hz #(
   parameter int CLK_FREQ_HZ = 12_000_000,
   parameter int OUT_FREQ_HZ = 1
) (
   input  logic CLK,
   input  logic RST_N,
`ifdef CLKDIV_TICK_EN
   output logic TICK,
`endif
   output logic BOARD_LED0
);

   localparam int HALF_CNT = CLK_FREQ_HZ / (2 * OUT_FREQ_HZ);
   localparam int CNT_W    = (HALF_CNT > 1) ? $clog2(HALF_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   generate
      if (HALF_CNT < 1) begin : g_bad_ratio
         $error("clock_divider_1hz: OUT_FREQ_HZ must not exceed CLK_FREQ_HZ/2");
      end
   endgenerate

   // Assert asynchronously, release on the second rising edge after RST_N goes high.
   logic [1:0] rst_sync;
   logic       run;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign run = rst_sync[1];

   logic [CNT_W-1:0] cnt;
   logic             led;
   logic             wrap;

   assign wrap = (cnt == CNT_MAX);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt <= '0;
         led <= 1'b0;
      end else if (!run) begin
         cnt <= '0;
         led <= 1'b0;
      end else if (wrap) begin
         cnt <= '0;
         led <= ~led;
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

   assign BOARD_LED0 = led;

`ifdef CLKDIV_TICK_EN
   // High in exactly the cycle the LED has just risen.
   logic tick;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tick <= 1'b0;
      end else if (!run) begin
         tick <= 1'b0;
      end else begin
         tick <= wrap & ~led;
      end
   end

   assign TICK = tick;
`endif

endmodule

// File: tb/tb_clock_divider_1hz.sv
// tb/tb_clock_divider_1hz.sv - self-checking bench for clock_divider_1hz
// Covers HALF_CNT=5 and HALF_CNT=1; TICK checked when CLKDIV_TICK_EN is defined.
module tb_clock_divider_1hz;

   logic clk = 1'b0;
   logic rst_n;
   logic led5;
   logic led1;
`ifdef CLKDIV_TICK_EN
   logic tick5;
   logic tick1;
`endif

   int total = 0;
   int bad   = 0;
   int e     = 0;   // rising edges seen since RST_N last went high

   always #5 clk = ~clk;

   clock_divider_1hz #(.CLK_FREQ_HZ(10), .OUT_FREQ_HZ(1)) dut5 (
      .CLK        (clk),
      .RST_N      (rst_n),
`ifdef CLKDIV_TICK_EN
      .TICK       (tick5),
`endif
      .BOARD_LED0 (led5)
   );

   clock_divider_1hz #(.CLK_FREQ_HZ(2), .OUT_FREQ_HZ(1)) dut1 (
      .CLK        (clk),
      .RST_N      (rst_n),
`ifdef CLKDIV_TICK_EN
      .TICK       (tick1),
`endif
      .BOARD_LED0 (led1)
   );

   // Reference: two edges of synchronizer latency, then c counting edges;
   // LED is the parity of completed half-periods, TICK marks each rising LED edge.
   function automatic logic exp_led(input int edges, input int half);
      int c;
      c = edges - 2;
      if (c <= 0) return 1'b0;
      return ((c / half) % 2) == 1;
   endfunction

   function automatic logic exp_tick(input int edges, input int half);
      int c;
      c = edges - 2;
      if (c <= 0) return 1'b0;
      return (c % (2 * half)) == half;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, e);
      end
   endtask

   task automatic check_all();
      check("led_half5", {31'b0, led5}, {31'b0, exp_led(e, 5)});
      check("led_half1", {31'b0, led1}, {31'b0, exp_led(e, 1)});
`ifdef CLKDIV_TICK_EN
      check("tick_half5", {31'b0, tick5}, {31'b0, exp_tick(e, 5)});
      check("tick_half1", {31'b0, tick1}, {31'b0, exp_tick(e, 1)});
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rst_n) e++;
      check_all();
   endtask

   // Called at posedge+1: drop reset between edges, check outputs clear with no clock,
   // hold for n edges, then release between edges.
   task automatic mid_reset(input int n);
      #2;
      rst_n = 1'b0;
      #1;
      e = 0;
      check("async_led5", {31'b0, led5}, 32'd0);
      check("async_led1", {31'b0, led1}, 32'd0);
`ifdef CLKDIV_TICK_EN
      check("async_tick5", {31'b0, tick5}, 32'd0);
`endif
      repeat (n) step();
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      logic prev;
      int   last;
      int   trans;

      rst_n = 1'b0;
      repeat (3) step();

      #2;
      rst_n = 1'b1;
      repeat (6) step();
      check("pre_first_rise", {31'b0, led5}, 32'd0);
      step();
      check("first_rise_edge7", {31'b0, led5}, 32'd1);

      prev  = led5;
      last  = e;
      trans = 0;
      repeat (100) begin
         step();
         if (led5 !== prev) begin
            trans++;
            check("phase_len", e - last, 32'd5);
            last = e;
            prev = led5;
         end
      end
      check("transitions_100", trans, 32'd20);

      check("led_high_before_pulse", {31'b0, led5}, 32'd1);
      mid_reset(2);
      repeat (12) step();

      for (int i = 0; i < 10; i++) begin
         repeat ($urandom_range(1, 40)) step();
         mid_reset($urandom_range(1, 4));
      end
      repeat (25) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
